// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port synchronous 2K x 8 display RAM between
// the text-scan video fetch path (strict priority, fixed latency) and the CPU
// bus (req/ack handshake). CPU request cycles lost to video are counted in a
// saturating debug counter.
module vram_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_pixel,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [CNT_W-1:0]  collision_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_CAP,
    WR_DONE,
    ACK
  } cpu_state_t;

  cpu_state_t state;

  // Video pipeline valid bits: stage 1 = address on RAM port, stage 2 = data
  // coming out of the RAM.
  logic vid_p1;
  logic vid_p2;

  // A CPU access may only start from IDLE and only when video leaves the slot.
  logic cpu_issue;
  logic collision;

  assign cpu_issue = (state == IDLE) && cpu_req && !vid_req;
  assign collision = (state == IDLE) && cpu_req && vid_req;

  // Address slot arbitration: video always wins, an idle CPU request fills
  // otherwise-empty slots; a write strobe never lasts more than one cycle.
  always_ff @(posedge clk_pixel) begin
    // NOTE: reset is sampled on the clock edge and all state uses <= so every
    // block sees pre-edge values regardless of evaluation order.
    if (!rst_n) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else if (vid_req) begin
      ram_addr <= vid_addr;
      ram_we   <= 1'b0;
    end else if (cpu_issue) begin
      ram_addr  <= cpu_addr;
      ram_we    <= cpu_we;
      ram_wdata <= cpu_wdata;
    end else begin
      ram_we <= 1'b0;
    end
  end

  // Fixed two-edge video pipeline: capture RAM data two edges after issue.
  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      vid_p1    <= 1'b0;
      vid_p2    <= 1'b0;
      vid_valid <= 1'b0;
      vid_data  <= '0;
    end else begin
      vid_p1    <= vid_req;
      vid_p2    <= vid_p1;
      vid_valid <= vid_p2;
      if (vid_p2) begin
        vid_data <= ram_rdata;
      end
    end
  end

  // CPU transaction FSM: once issued, an access runs to its ack regardless of
  // video traffic or cpu_req dropping.
  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      state     <= IDLE;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_issue) begin
            state <= cpu_we ? WR_DONE : RD_WAIT;
          end
        end
        RD_WAIT: state <= RD_CAP;
        RD_CAP: begin
          cpu_rdata <= ram_rdata;
          cpu_ack   <= 1'b1;
          state     <= ACK;
        end
        WR_DONE: begin
          cpu_ack <= 1'b1;
          state   <= ACK;
        end
        ACK: begin
          cpu_ack <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of idle CPU request cycles pre-empted by video.
  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      collision_cnt <= '0;
    end else if (collision && (collision_cnt != {CNT_W{1'b1}})) begin
      collision_cnt <= collision_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus tasks push expected data and
// arrival cycle; a negedge monitor pops and compares on vid_valid / cpu_ack.
module tb_vram_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic              clk_pixel = 1'b0;
  logic              rst_n;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [CNT_W-1:0]  collision_cnt;

  // Narrow-counter twin, same stimulus, used to reach saturation quickly.
  logic [DATA_W-1:0] s_vid_data, s_cpu_rdata, s_ram_wdata;
  logic              s_vid_valid, s_cpu_ack, s_ram_we;
  logic [ADDR_W-1:0] s_ram_addr;
  logic [1:0]        sat_cnt;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_pixel(clk_pixel), .rst_n(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .collision_cnt(collision_cnt)
  );

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(2)) dut_sat (
    .clk_pixel(clk_pixel), .rst_n(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(s_vid_data), .vid_valid(s_vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(s_cpu_rdata), .cpu_ack(s_cpu_ack),
    .ram_addr(s_ram_addr), .ram_we(s_ram_we), .ram_wdata(s_ram_wdata), .ram_rdata(ram_rdata),
    .collision_cnt(sat_cnt)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Behavioural single-port synchronous RAM (read returns pre-write contents).
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always @(posedge clk_pixel) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk_pixel) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int we_pulses = 0;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
    bit                rd;
  } exp_t;

  exp_t vid_q[$];
  exp_t cpu_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor, sampling half a cycle away from the active edge.
  always @(negedge clk_pixel) begin
    exp_t e;
    if (ram_we) we_pulses++;
    if (vid_valid) begin
      if (vid_q.size() == 0) check("vid_valid_unexpected", 1, 0);
      else begin
        e = vid_q.pop_front();
        check("vid_data", vid_data, e.data);
        check("vid_latency", cyc, e.cyc);
      end
    end
    if (cpu_ack) begin
      if (cpu_q.size() == 0) check("cpu_ack_unexpected", 1, 0);
      else begin
        e = cpu_q.pop_front();
        if (e.rd) check("cpu_rdata", cpu_rdata, e.data);
        check("cpu_latency", cyc, e.cyc);
      end
    end
  end

  // Called just after a negedge; one vid_req cycle, result due 3 edges later.
  task automatic vid_fetch(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    vid_req  = 1'b1;
    vid_addr = a;
    vid_q.push_back('{data: d, cyc: cyc + 3, rd: 1'b1});
    @(negedge clk_pixel);
    vid_req = 1'b0;
  endtask

  // Called just after a negedge; stall = edges lost to video before issue.
  task automatic cpu_access(input bit we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] exp_rd,
                            input int stall, input int hold_extra);
    int n;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    cpu_q.push_back('{data: exp_rd, cyc: cyc + stall + (we ? 2 : 3), rd: !we});
    n = 0;
    do begin
      @(negedge clk_pixel);
      n++;
    end while (!cpu_ack && n < 20);
    if (!cpu_ack) check("cpu_ack_timeout", 0, 1);
    repeat (hold_extra) @(negedge clk_pixel);
    cpu_req = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_vid"}, {vid_valid, vid_data}, 0);
    check({tag, "_cpu"}, {cpu_ack, cpu_rdata}, 0);
    check({tag, "_ram"}, {ram_we, ram_addr, ram_wdata}, 0);
    check({tag, "_cnt"}, collision_cnt, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
    mem[11'h123] = 8'h5A;
    mem[11'h010] = 8'h3C;
    for (int i = 0; i < 5; i++) mem[11'h200 + i] = 8'hA0 + 8'(i);

    // 1. Reset with both requesters active: outputs stay zero.
    rst_n = 1'b0; vid_req = 1'b1; vid_addr = 11'h3FF;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h155; cpu_wdata = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_pixel);
      check_outputs_zero("reset");
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    @(negedge clk_pixel);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_pixel);
    check_outputs_zero("post_reset");

    // 2. Single video fetch.
    vid_fetch(11'h123, 8'h5A);
    check("vid_ram_addr", ram_addr, 11'h123);
    repeat (4) @(negedge clk_pixel);

    // 3. CPU write then read of the top address; held req during ACK.
    w0 = we_pulses;
    cpu_access(1'b1, 11'h7FF, 8'hC3, 8'h00, 0, 0);
    repeat (2) @(negedge clk_pixel);
    check("write_we_pulses", we_pulses - w0, 1);
    check("write_mem", mem[11'h7FF], 8'hC3);
    cpu_access(1'b0, 11'h7FF, 8'h00, 8'hC3, 0, 1);
    repeat (4) @(negedge clk_pixel);

    // 4. Collision: read stalled by a 5-cycle video burst.
    fork
      cpu_access(1'b0, 11'h010, 8'h00, 8'h3C, 5, 0);
      for (int i = 0; i < 5; i++) vid_fetch(11'h200 + 11'(i), 8'hA0 + 8'(i));
    join
    repeat (3) @(negedge clk_pixel);
    check("collision_cnt", collision_cnt, 5);
    check("collision_sat", sat_cnt, 2'b11);

    // 5. Write followed one cycle later by a video read of the same address.
    fork
      cpu_access(1'b1, 11'h040, 8'h11, 8'h00, 0, 0);
      begin
        @(negedge clk_pixel);
        vid_fetch(11'h040, 8'h11);
      end
    join
    repeat (4) @(negedge clk_pixel);
    check("collision_sat_hold", sat_cnt, 2'b11);

    // 6. Reset while the read sits in RD_CAP: no ack, FSM back in IDLE.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h7FF;
    repeat (2) @(negedge clk_pixel);
    rst_n = 1'b0; cpu_req = 1'b0;
    @(negedge clk_pixel);
    check_outputs_zero("mid_read_reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk_pixel);
    check("no_ack_after_reset", cpu_ack, 0);
    cpu_access(1'b1, 11'h055, 8'h77, 8'h00, 0, 0);
    repeat (2) @(negedge clk_pixel);
    cpu_access(1'b0, 11'h055, 8'h00, 8'h77, 0, 0);
    repeat (4) @(negedge clk_pixel);

    check("vid_queue_drained", vid_q.size(), 0);
    check("cpu_queue_drained", cpu_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous display RAM (2K x 8) between two requesters: the video text-scan fetch path and the CPU bus.
- Sits between the CPU memory decode, the character/text display generator, and the VRAM instance.
- Video fetches have strict priority and a fixed latency, which keeps the scan timing deterministic.
- CPU accesses are stalled with a req/ack handshake. Deferred CPU cycles are counted for debug.

Parameters:
ADDR_W, 11, VRAM address width (2K locations)
DATA_W, 8, VRAM data width
CNT_W, 16, width of saturating collision counter

Ports:
clk_pixel  in  1  pixel clock; the only clock
rst_n  in  1  synchronous, active-low reset
vid_req  in  1  video fetch request, one-cycle pulse
vid_addr  in  ADDR_W  video fetch address, valid with vid_req
vid_data  out  DATA_W  fetched video byte, held until next vid_valid
vid_valid  out  1  one-cycle pulse, vid_data updated
cpu_req  in  1  CPU access request, level, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
cpu_addr  in  ADDR_W  CPU address; stable while cpu_req
cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req
cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack on reads, held afterwards
cpu_ack  out  1  one-cycle completion pulse
ram_addr  out  ADDR_W  registered RAM address
ram_we  out  1  registered RAM write enable
ram_wdata  out  DATA_W  registered RAM write data
ram_rdata  in  DATA_W  RAM read data; appears the cycle after ram_addr is sampled
collision_cnt  out  CNT_W  saturating count of CPU issue cycles lost to video

Behaviour:
- Reset (rst_n=0 at an edge):
  - All outputs go to 0; CPU FSM goes to IDLE; the video pipeline valid bits clear.
  - An in-flight transaction is dropped: no ack and no vid_valid is produced for it. A write already registered onto ram_we is deasserted.
- Address slot arbitration (edge E0):
  - If vid_req=1: ram_addr<=vid_addr and ram_we<=0; video pipeline stage 1 is set.
  - Else if the CPU FSM is IDLE and cpu_req=1: ram_addr<=cpu_addr, ram_we<=cpu_we, ram_wdata<=cpu_wdata; the FSM advances.
  - Else ram_we<=0 and ram_addr holds its value.
- Video pipeline latency:
  - RAM samples the address at E1; ram_rdata is valid after E1.
  - At E2: vid_data<=ram_rdata and vid_valid=1 for exactly one cycle.
  - Back-to-back vid_req on consecutive cycles is legal and fully pipelined: one vid_valid per request, in order.
- CPU FSM states: IDLE, RD_WAIT, RD_CAP, WR_DONE, ACK.
  - IDLE -> RD_WAIT on a read issue at E0.
  - RD_WAIT -> RD_CAP at E1.
  - RD_CAP: at E2, cpu_rdata<=ram_rdata and cpu_ack<=1; goes to ACK.
  - IDLE -> WR_DONE on a write issue at E0. At E1 the write is committed in RAM, ram_we<=0 unless video holds the slot, cpu_ack<=1; goes to ACK.
  - ACK: cpu_ack is high this cycle; cpu_req is ignored; the next edge returns to IDLE with cpu_ack<=0.
  - Minimum spacing of CPU transactions: read 4 cycles, write 3 cycles.
- Once a CPU access is issued it cannot be pre-empted. Video fetches arriving during RD_WAIT, RD_CAP, WR_DONE or ACK take the address slot without disturbing the CPU transaction.
- Ordering: a CPU write issued at E0 followed by vid_req to the same address at E1 returns the new data. Video and CPU reads never reorder relative to their own issue order.
- Collision counter: increments at each edge where FSM=IDLE, cpu_req=1 and vid_req=1. It saturates at 2^CNT_W-1 and never wraps. It is cleared only by reset.
- Simultaneous vid_req and cpu_req in IDLE: video wins. The CPU issues at the first later edge without vid_req, so the worst-case CPU stall equals the length of the vid_req burst.
- cpu_req dropping before ack is a protocol error; an already-issued access still completes and acks.

Test Plan:
1. Reset sequence: hold rst_n=0 for 3 edges with cpu_req=1 and vid_req=1 -> all outputs 0 throughout; first issue occurs only after rst_n=1.
2. Video fetch: RAM[0x123]=0x5A, single vid_req with vid_addr=0x123 at E0 -> ram_addr=0x123 after E0; vid_data=0x5A and vid_valid=1 for exactly the cycle after E2.
3. CPU write then read:
   - Write 0xC3 to 0x7FF -> ram_we pulses once, cpu_ack arrives 2 cycles after issue.
   - Read 0x7FF -> cpu_rdata=0xC3 with cpu_ack 3 cycles after issue.
   - A held cpu_req produces no duplicate access during the ACK cycle.
4. Collision: cpu_req (read 0x010) with vid_req high for 5 consecutive cycles -> CPU issues on the 6th edge; collision_cnt=5; 5 vid_valid pulses, in order.
5. Write-before-read hazard: CPU write 0x11 to 0x040 issued at E0, vid_req for 0x040 at E1 -> vid_data=0x11.
6. Reset mid-read: rst_n=0 in RD_CAP -> no cpu_ack; FSM is IDLE after release. Saturation: force collision_cnt to 0xFFFF, add one more collision -> value stays 0xFFFF.
